// File: rtl/cdtv_subcode_tx_pkg.sv
// Shared constants, FSM state type and frame-counter helper for the subcode transmitter.
package cdtv_subcode_tx_pkg;

  localparam int FRAMES_PER_BLOCK = 98;
  localparam int SYNC_FRAMES      = 2;
  localparam int BITS_PER_FRAME   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  function automatic logic [6:0] next_frame(input logic [6:0] fn);
    return (fn == 7'(FRAMES_PER_BLOCK - 1)) ? 7'd0 : fn + 7'd1;
  endfunction

endpackage

// File: rtl/cdtv_subcode_tx_if.sv
// Byte-source, host serial port and status signals of the subcode transmitter.
interface cdtv_subcode_tx_if;

  logic       ENABLE;
  logic [7:0] SUB_DATA;
  logic       SUB_VALID;
  logic       SUB_READY;
  logic       SCCK;
  logic       SBCP;
  logic       EFFK;
  logic       SCOR;
  logic [6:0] FRAME_NUM;
  logic       UNDERRUN;

  modport master (
    input  ENABLE, SUB_DATA, SUB_VALID, SCCK,
    output SUB_READY, SBCP, EFFK, SCOR, FRAME_NUM, UNDERRUN
  );

  modport slave (
    output ENABLE, SUB_DATA, SUB_VALID, SCCK,
    input  SUB_READY, SBCP, EFFK, SCOR, FRAME_NUM, UNDERRUN
  );

endinterface

// File: rtl/cdtv_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with one-cycle rise/fall pulses.
module cdtv_sync_edge (
  input  logic CLK,
  input  logic IFRST_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge CLK or negedge IFRST_n) begin
    if (!IFRST_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/cdtv_subcode_tx.sv
// Drive-side P-W subcode transmitter: per-frame EFFK/SCOR pulses and one byte
// shifted out MSB first on SBCP, advancing on synchronised SCCK falling edges.
module cdtv_subcode_tx
  import cdtv_subcode_tx_pkg::*;
#(
  parameter int         FRAME_DIV  = 965,
  parameter int         EFFK_WIDTH = 4,
  parameter logic [7:0] SYNC_FILL  = 8'h00
) (
  input logic              CLK,
  input logic              IFRST_n,
  cdtv_subcode_tx_if.master bus
);

  localparam int             TW          = $clog2(FRAME_DIV);
  localparam logic [TW-1:0]  T_LAST      = TW'(FRAME_DIV - 1);
  localparam logic [TW-1:0]  T_PULSE_END = TW'(EFFK_WIDTH - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    bits_sent;
  logic [7:0]    tx_shift;
  logic [6:0]    frame_num;
  logic          effk, scor, sub_ready, underrun;
  logic          scck_rise, scck_fall;

  cdtv_sync_edge u_scck_sync (
    .CLK     (CLK),
    .IFRST_n (IFRST_n),
    .din     (bus.SCCK),
    .rise    (scck_rise),
    .fall    (scck_fall)
  );

  // Rising edges are host sample points only; edges in T and T+1 are ignored.
  logic shift_ok;
  assign shift_ok = (state == ST_SHIFT) && (timer > TW'(1)) && scck_fall && !scck_rise
                    && (bits_sent < 4'(BITS_PER_FRAME));

  logic       go_start;
  logic [6:0] next_fn;
  assign go_start = bus.ENABLE && ((state == ST_IDLE) || ((state == ST_SHIFT) && (timer == T_LAST)));
  assign next_fn  = (state == ST_IDLE) ? 7'd0 : next_frame(frame_num);

  always_ff @(posedge CLK or negedge IFRST_n) begin
    if (!IFRST_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bits_sent <= 4'd0;
      tx_shift  <= 8'h00;
      frame_num <= 7'd0;
      effk      <= 1'b0;
      scor      <= 1'b0;
      sub_ready <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if ((state != ST_IDLE) && (timer == T_PULSE_END)) begin
        effk <= 1'b0;
        scor <= 1'b0;
      end
      case (state)
        ST_IDLE: ;
        ST_START: begin
          state     <= ST_SHIFT;
          timer     <= timer + 1'b1;
          sub_ready <= 1'b0;
          tx_shift  <= (sub_ready && bus.SUB_VALID) ? bus.SUB_DATA : SYNC_FILL;
          underrun  <= sub_ready & ~bus.SUB_VALID;
        end
        ST_SHIFT: begin
          timer <= timer + 1'b1;
          if (shift_ok) begin
            tx_shift  <= {tx_shift[6:0], 1'b0};
            bits_sent <= bits_sent + 4'd1;
          end
          if ((timer == T_LAST) && !bus.ENABLE) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bits_sent <= 4'd0;
            tx_shift  <= 8'h00;
            frame_num <= 7'd0;
            effk      <= 1'b0;
            scor      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Frame start: unsent bits of the previous frame are dropped here.
      if (go_start) begin
        state     <= ST_START;
        timer     <= '0;
        bits_sent <= 4'd0;
        tx_shift  <= 8'h00;
        frame_num <= next_fn;
        effk      <= 1'b1;
        scor      <= (next_fn == 7'd0);
        sub_ready <= (next_fn >= 7'(SYNC_FRAMES));
      end
    end
  end

  assign bus.SUB_READY = sub_ready;
  assign bus.SBCP      = tx_shift[7];
  assign bus.EFFK      = effk;
  assign bus.SCOR      = scor;
  assign bus.FRAME_NUM = frame_num;
  assign bus.UNDERRUN  = underrun;

endmodule

// File: tb/tb_cdtv_subcode_tx.sv
// Directed bench for cdtv_subcode_tx: per-cycle check against a frame-level model plus literal checks.
module tb_cdtv_subcode_tx;

  localparam int DIV = 200;
  localparam int W   = 4;

  logic CLK     = 1'b0;
  logic IFRST_n = 1'b1;

  cdtv_subcode_tx_if bus();

  cdtv_subcode_tx #(.FRAME_DIV(DIV), .EFFK_WIDTH(W), .SYNC_FILL(8'h00)) dut (
    .CLK     (CLK),
    .IFRST_n (IFRST_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.SUB_READY, bus.SBCP, bus.EFFK, bus.SCOR, bus.UNDERRUN, bus.FRAME_NUM};
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Frame-level model: position in frame, frame number, byte on the wire, host bits taken.
  bit         m_act = 1'b0;
  bit         m_und = 1'b0;
  int         m_age = 0;
  int         m_fn = 0;
  int         m_falls = 0;
  logic [7:0] m_byte = 8'h00;
  bit         sc1 = 1'b0, sc2 = 1'b0, sc3 = 1'b0;

  initial forever begin
    logic [11:0] exp;
    logic        e_rdy, e_bit, e_eff, e_scor, e_und;
    bit          fall_now;
    @(negedge CLK);
    if (chk_on) begin
      if (!IFRST_n) begin
        m_act = 1'b0;
        sc1 = 1'b0; sc2 = 1'b0; sc3 = 1'b0;
        check("reset_cycle_outputs", 32'(outs()), 32'd0);
      end else begin
        exp = 12'd0;
        if (m_act) begin
          e_rdy  = (m_age == 0) && (m_fn >= 2);
          e_bit  = (m_age >= 1 && m_falls < 8) ? m_byte[3'(7 - m_falls)] : 1'b0;
          e_eff  = (m_age < W);
          e_scor = e_eff && (m_fn == 0);
          e_und  = (m_age == 1) && m_und;
          exp    = {e_rdy, e_bit, e_eff, e_scor, e_und, 7'(m_fn)};
        end
        check("cycle_outputs", 32'(outs()), 32'(exp));
        fall_now = !sc2 && sc3;
        if (m_act) begin
          if (m_age == 0) begin
            m_und  = (m_fn >= 2) && !bus.SUB_VALID;
            m_byte = ((m_fn >= 2) && bus.SUB_VALID) ? bus.SUB_DATA : 8'h00;
          end
          if (m_age >= 2 && fall_now && m_falls < 8) m_falls++;
          if (m_age == DIV - 1) begin
            if (bus.ENABLE) begin
              m_age = 0; m_fn = (m_fn + 1) % 98; m_falls = 0;
            end else begin
              m_act = 1'b0;
            end
          end else begin
            m_age++;
          end
        end else if (bus.ENABLE) begin
          m_act = 1'b1; m_age = 0; m_fn = 0; m_falls = 0;
        end
        sc3 = sc2; sc2 = sc1; sc1 = bus.SCCK;
      end
    end
  end

  // Block-level observations: SCOR spacing, handshakes per block, 97->0 wraps.
  int   n_scor = 0, t_scor = 0, last_int = 0, hs_cnt = 0, last_hs = 0, wraps = 0;
  logic p_scor = 1'b0;
  logic [6:0] p_fn = 7'd0;

  initial forever begin
    @(negedge CLK);
    if (bus.SCOR && !p_scor) begin
      if (n_scor > 0) begin
        last_int = cyc - t_scor;
        last_hs  = hs_cnt;
      end
      n_scor++;
      t_scor = cyc;
      hs_cnt = 0;
    end
    if (bus.SUB_READY && bus.SUB_VALID) hs_cnt++;
    if (p_fn == 7'd97 && bus.FRAME_NUM == 7'd0) wraps++;
    p_scor = bus.SCOR;
    p_fn   = bus.FRAME_NUM;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_start(input int fn, input int budget, input string tag);
    logic p;
    bit   ok;
    p  = bus.EFFK;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge CLK);
      #1;
      if (bus.EFFK && !p && int'(bus.FRAME_NUM) == fn) ok = 1'b1;
      p = bus.EFFK;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: frame %0d start not seen within %0d cycles", tag, fn, budget);
    end
  endtask

  // Host side: sample SBCP at each SCCK rise, h CLK cycles per level.
  task automatic burst(input int n, input int h, output logic [19:0] hb);
    hb = 20'd0;
    for (int i = 0; i < n; i++) begin
      bus.SCCK = 1'b1;
      hb = {hb[18:0], bus.SBCP};
      step(h);
      bus.SCCK = 1'b0;
      step(h);
    end
  endtask

  initial begin
    logic [19:0] hb;
    int t5, tnow;
    int c_e, c_s, c_r, c_u, c_b;
    bus.ENABLE = 1'b0; bus.SUB_DATA = 8'h00; bus.SUB_VALID = 1'b0; bus.SCCK = 1'b0;
    #1 IFRST_n = 1'b0;
    chk_on = 1'b1;
    step(5);
    check("reset_state", 32'(outs()), 32'd0);

    // Underrun source, sync frames and frame-0 pulses.
    IFRST_n = 1'b1;
    bus.ENABLE = 1'b1;
    wait_start(0, 20, "first_start");
    c_e = 0; c_s = 0; c_r = 0; c_u = 0; c_b = 0;
    for (int i = 0; i < DIV; i++) begin
      if (bus.EFFK) c_e++;
      if (bus.SCOR) c_s++;
      if (bus.SUB_READY) c_r++;
      if (bus.UNDERRUN) c_u++;
      if (bus.SBCP) c_b++;
      step(1);
    end
    check("frame0_effk_cycles", 32'(c_e), 32'd4);
    check("frame0_scor_cycles", 32'(c_s), 32'd4);
    check("frame0_ready_cycles", 32'(c_r), 32'd0);
    check("frame0_underrun", 32'(c_u), 32'd0);
    check("frame0_sbcp_ones", 32'(c_b), 32'd0);
    wait_start(2, 2 * DIV, "frame2_start");
    check("frame2_ready", 32'(bus.SUB_READY), 32'd1);
    step(1);
    check("frame2_underrun_pulse", 32'(bus.UNDERRUN), 32'd1);
    step(1);
    check("frame2_underrun_end", 32'(bus.UNDERRUN), 32'd0);

    // One byte out to the host.
    IFRST_n = 1'b0;
    step(3);
    bus.SUB_DATA = 8'hA5; bus.SUB_VALID = 1'b1;
    IFRST_n = 1'b1;
    wait_start(2, 3 * DIV + 10, "a5_frame_start");
    step(1);
    bus.SUB_VALID = 1'b0;
    step(W + 3);
    burst(8, 10, hb);
    check("host_byte_a5", 32'(hb[7:0]), 32'h0000_00A5);
    check("sbcp_after_8th_fall", 32'(bus.SBCP), 32'd0);

    // Incrementing source over 100 frames, with a short and an over-long burst.
    IFRST_n = 1'b0;
    step(3);
    bus.SUB_DATA = 8'h5A; bus.SUB_VALID = 1'b1;
    n_scor = 0; hs_cnt = 0; wraps = 0; last_int = 0; last_hs = 0;
    IFRST_n = 1'b1;
    t5 = 0;
    for (int f = 0; f < 100; f++) begin
      wait_start(f % 98, 2 * DIV + 10, "frame_sequence");
      tnow = cyc;
      step(1);
      if (f % 98 >= 2) bus.SUB_DATA = bus.SUB_DATA + 8'd1;
      if (f == 5) begin
        t5 = tnow;
        step(W + 3);
        burst(5, 10, hb);
        check("five_bits_of_5d", 32'(hb[4:0]), 32'h0000_000B);
      end
      if (f == 6) begin
        check("frame_period", 32'(tnow - t5), 32'(DIV));
        step(W + 3);
        burst(20, 4, hb);
        check("fresh_byte_5e", 32'(hb[19:12]), 32'h0000_005E);
        check("extra_pulses_zero", 32'(hb[11:0]), 32'd0);
      end
    end
    check("scor_interval", 32'(last_int), 32'(98 * DIV));
    check("bytes_per_block", 32'(last_hs), 32'd96);
    check("frame_wraps", 32'(wraps), 32'd1);

    // ENABLE dropped mid-frame 10.
    wait_start(10, 10 * DIV, "frame10_start");
    step(50);
    bus.ENABLE = 1'b0;
    step(DIV - 51);
    check("frame10_last_cycle", 32'({bus.EFFK, bus.FRAME_NUM}), 32'h0000_000A);
    step(1);
    check("idle_after_wrap", 32'(outs()), 32'd0);
    step(20);
    check("idle_holds", 32'(outs()), 32'd0);
    bus.ENABLE = 1'b1;
    wait_start(0, 20, "reenable_start");
    check("reenable_scor", 32'(bus.SCOR), 32'd1);

    // Asynchronous reset in the middle of a shift.
    bus.SUB_DATA = 8'hFF;
    wait_start(2, 3 * DIV, "pre_reset_frame");
    step(1);
    step(W + 3);
    burst(2, 10, hb);
    check("sbcp_mid_shift", 32'(bus.SBCP), 32'd1);
    #2 IFRST_n = 1'b0;
    #1 check("async_reset_outputs", 32'(outs()), 32'd0);
    step(3);
    IFRST_n = 1'b1;
    wait_start(0, 20, "restart_start");
    check("restart_scor", 32'(bus.SCOR), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
